// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALUOp, funct and ALU control encodings plus FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] c_aluop_ldsd  = 2'b00;
    localparam logic [1:0] c_aluop_beq   = 2'b01;
    localparam logic [1:0] c_aluop_rtype = 2'b10;
    localparam logic [1:0] c_aluop_itype = 2'b11;

    // {funct7, funct3}
    localparam logic [9:0] c_funct_add  = 10'b0000000000;
    localparam logic [9:0] c_funct_sub  = 10'b0100000000;
    localparam logic [9:0] c_funct_or   = 10'b0000000110;
    localparam logic [9:0] c_funct_and  = 10'b0000000111;
    localparam logic [9:0] c_funct_mul  = 10'b0000001000;
    localparam logic [9:0] c_funct_divu = 10'b0000001101;

    localparam logic [3:0] c_ctrl_and  = 4'b0000;
    localparam logic [3:0] c_ctrl_or   = 4'b0001;
    localparam logic [3:0] c_ctrl_add  = 4'b0010;
    localparam logic [3:0] c_ctrl_sub  = 4'b0110;
    localparam logic [3:0] c_ctrl_mul  = 4'b1000;
    localparam logic [3:0] c_ctrl_divu = 4'b1001;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_muldiv
// Description : Iterative shift-add multiplier (low half), plus a restoring
//               unsigned divider when ALU_DIV_EN is defined. DATA_W steps.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
`ifdef ALU_DIV_EN
    input  logic              i_div,
`endif
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);
    import alu_pkg::*;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DATA_W - 1);

    logic              r_busy;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_a;    // multiplicand / divisor
    logic [DATA_W-1:0] r_b;    // multiplier / dividend shifting into quotient
    logic [DATA_W-1:0] r_acc;  // product accumulator / partial remainder
    logic [DATA_W-1:0] w_mul_acc;

    assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

`ifdef ALU_DIV_EN
    logic              r_div;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_sub;
    logic              w_ge;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_q_next;

    // A zero divisor always "fits", so every quotient bit becomes one.
    assign w_shift    = {r_acc, r_b[DATA_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_a});
    assign w_sub      = w_shift - {1'b0, r_a};
    assign w_rem_next = w_ge ? w_sub[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_q_next   = {r_b[DATA_W-2:0], w_ge};
    assign o_result   = r_div ? w_q_next : w_mul_acc;
`else
    assign o_result   = w_mul_acc;
`endif

    assign o_done = r_busy && (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
`ifdef ALU_DIV_EN
            r_div   <= 1'b0;
`endif
        end else if (i_abort) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_count <= c_last;
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
`ifdef ALU_DIV_EN
            r_div   <= i_div;
`endif
        end else if (r_busy) begin
`ifdef ALU_DIV_EN
            if (r_div) begin
                r_acc <= w_rem_next;
                r_b   <= w_q_next;
            end else begin
                r_acc <= w_mul_acc;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
            end
`else
            r_acc <= w_mul_acc;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
`endif
            if (r_count == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_exec
// Description : EX-stage ALU control decode and execute with iterative MUL.
//               Optional DIVU path enabled by macro ALU_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_exec #(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 10,
    parameter int CTRL_W  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [1:0]         ALUOp_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  src2_i,
    input  logic               flush_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic [DATA_W-1:0]  result_o,
    output logic               zero_o,
    output logic               valid_o,
    output logic               illegal_o,
    output logic               stall_o
);
    import alu_pkg::*;

    state_t            r_state;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_illegal;
    logic              r_valid;

    logic [CTRL_W-1:0] w_ctrl;
    logic              w_illegal;
    logic              w_multi;
    logic              w_accept;
    logic [DATA_W-1:0] w_alu;
    logic              w_md_done;
    logic [DATA_W-1:0] w_md_result;

    always_comb begin
        w_ctrl    = c_ctrl_add;
        w_illegal = 1'b0;
        case (ALUOp_i)
            c_aluop_ldsd, c_aluop_itype: w_ctrl = c_ctrl_add;
            c_aluop_beq:                 w_ctrl = c_ctrl_sub;
            default: begin
                case (funct_i)
                    c_funct_or:   w_ctrl = c_ctrl_or;
                    c_funct_and:  w_ctrl = c_ctrl_and;
                    c_funct_add:  w_ctrl = c_ctrl_add;
                    c_funct_sub:  w_ctrl = c_ctrl_sub;
                    c_funct_mul:  w_ctrl = c_ctrl_mul;
`ifdef ALU_DIV_EN
                    c_funct_divu: w_ctrl = c_ctrl_divu;
`endif
                    default: begin
                        w_ctrl    = c_ctrl_and;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        w_alu = src1_i & src2_i;
        case (w_ctrl)
            c_ctrl_or:  w_alu = src1_i | src2_i;
            c_ctrl_add: w_alu = src1_i + src2_i;
            c_ctrl_sub: w_alu = src1_i - src2_i;
            default:    w_alu = src1_i & src2_i;
        endcase
    end

`ifdef ALU_DIV_EN
    assign w_multi = (w_ctrl == c_ctrl_mul) || (w_ctrl == c_ctrl_divu);
`else
    assign w_multi = (w_ctrl == c_ctrl_mul);
`endif

    // Flush wins over a request in the same cycle.
    assign w_accept = valid_i && ready_o && !flush_i;

    alu_iter_muldiv #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk      (clk_i),
        .rst      (!rst_i),
        .i_start  (w_accept && w_multi),
`ifdef ALU_DIV_EN
        .i_div    (w_ctrl == c_ctrl_divu),
`endif
        .i_abort  (flush_i && (r_state == S_BUSY)),
        .i_a      (src1_i),
        .i_b      (src2_i),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_ctrl    <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ctrl <= w_ctrl;
                        if (w_multi) begin
                            r_state   <= S_BUSY;
                            r_zero    <= 1'b0;
                            r_illegal <= 1'b0;
                        end else begin
                            r_result  <= w_alu;
                            r_zero    <= (w_alu == '0);
                            r_illegal <= w_illegal;
                            r_valid   <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (w_md_done) begin
                        r_result <= w_md_result;
                        r_zero   <= (w_md_result == '0);
                        r_valid  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready_o   = (r_state == S_IDLE);
    assign stall_o   = !ready_o;
    assign ALUCtrl_o = r_ctrl;
    assign result_o  = r_result;
    assign valid_o   = r_valid;
    assign zero_o    = r_valid && r_zero;
    assign illegal_o = r_valid && r_illegal;

endmodule
`default_nettype wire

// File: doc/alu_ctrl_exec.md
Name: alu_ctrl_exec

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp_i/funct_i into a 4-bit ALU control code and executes the operation on registered operands.
- Single-cycle ops complete in one cycle; MUL runs on an iterative shift-add datapath.
- Sits in the EX stage. Raises stall_o to hold IF/ID/EX while a multi-cycle op is in flight, and accepts flush_i from the hazard unit.

Parameters:
- DATA_W, 32, operand/result width; also the MUL (and DIV) iteration count.
- FUNCT_W, 10, funct width: {funct7, funct3}.
- CTRL_W, 4, ALU control code width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- valid_i  in  1  operation request
- ready_o  out  1  block can accept a request
- funct_i  in  FUNCT_W  {funct7, funct3}
- ALUOp_i  in  2  00 LD/SD, 01 BEQ, 10 R-type, 11 I-type
- src1_i  in  DATA_W  operand A
- src2_i  in  DATA_W  operand B
- flush_i  in  1  abort in-flight op
- ALUCtrl_o  out  CTRL_W  registered decoded control code of the last accepted op
- result_o  out  DATA_W  result
- zero_o  out  1  result_o == 0, qualified by valid_o
- valid_o  out  1  one-cycle result strobe
- illegal_o  out  1  R-type funct not decoded, qualified by valid_o
- stall_o  out  1  multi-cycle op busy

Behaviour:
- One clock domain: clk_i. Reset: rst_i is synchronous and active-low. Reset applies only at a clk_i edge while rst_i == 0.
- Reset values: ready_o=1, valid_o=0, stall_o=0, result_o=0, ALUCtrl_o=0000, zero_o=0, illegal_o=0, state=IDLE, counter=0.
- Decode (combinational, internal):
  - ALUOp 11 -> ADD 0010; ALUOp 00 -> ADD 0010; ALUOp 01 -> SUB 0110.
  - ALUOp 10, funct 0000000110 -> OR 0001; 0000000111 -> AND 0000; 0000000000 -> ADD 0010; 0100000000 -> SUB 0110; 0000001000 -> MUL 1000.
  - Any other R-type funct -> 0000 (AND) with illegal flag set.
- Handshake: accept when valid_i && ready_o. ready_o = (state == IDLE) = !stall_o.
- FSM states: IDLE, BUSY.
- IDLE, accepted single-cycle op:
  - Result, ALUCtrl_o, zero_o and illegal_o registered at that edge; valid_o=1 for exactly the next cycle.
  - Latency 1. A back-to-back accept every cycle is allowed.
- IDLE, accepted MUL:
  - Latch operands; counter = DATA_W-1; go to BUSY; valid_o=0; ALUCtrl_o=1000.
- BUSY:
  - One shift-add step per edge.
  - When counter == 0: register the low DATA_W bits of the product, valid_o=1, go to IDLE.
  - ready_o is low for exactly DATA_W cycles. valid_o appears DATA_W edges after the accept.
  - valid_i is ignored while BUSY.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W, no overflow flag. MUL returns the low half, which is identical for signed and unsigned operands.
- flush_i:
  - In BUSY: at the next edge go to IDLE, no valid_o, result_o unchanged.
  - In IDLE: flush_i suppresses the accept in that cycle.
  - flush_i has priority over valid_i.
- Reset mid-MUL: abort immediately to reset values.
- valid_o and an accept in the same cycle are legal (IDLE after completion).

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined:
  - R-type funct 0000001101 (DIVU) decodes to ctrl 1001 and runs a restoring unsigned divider.
  - Timing and flush behaviour identical to MUL (DATA_W cycles).
  - Divide by zero returns all ones and still takes DATA_W cycles.
- Undefined: funct 0000001101 decodes as illegal: ctrl 0000, AND result, illegal_o=1, latency 1.

Decomposition:
- Package alu_pkg: ALUOp codes, FUNCT codes, ALU_CTRL codes (including DIVU 1001), FSM state typedef.
- One sub-module, alu_iter_muldiv: counter, operand/accumulator shift registers, start/done/abort, DIV path under ALU_DIV_EN.
- Decode and single-cycle datapath stay in alu_ctrl_exec.

Test Plan:
- Reset: rst_i=0 for 2 edges -> ready_o=1, valid_o=0, result_o=0, ALUCtrl_o=0000.
- ALUOp=10, funct=0100000000, src1=5, src2=5 -> next cycle valid_o=1, result_o=0, zero_o=1, ALUCtrl_o=0110. Then ALUOp=01, src1=3, src2=7 -> result_o=0xFFFFFFFC, zero_o=0.
- MUL src1=0xFFFFFFFF, src2=3 (DATA_W=32) -> stall_o high 32 cycles, valid_o on the 32nd edge after accept, result_o=0xFFFFFFFD; valid_i held high during BUSY is not accepted.
- MUL accepted, flush_i pulsed on busy cycle 10 -> IDLE next edge, no valid_o, ready_o=1; next ADD 2+2 -> result_o=4 with latency 1.
- ALUOp=10, funct=0000000101 -> valid_o=1, illegal_o=1, ALUCtrl_o=0000, result_o=src1&src2. With ALU_DIV_EN: funct 0000001101, 100/7 -> result_o=14 after 32 cycles; 9/0 -> 0xFFFFFFFF.
- Reset asserted on busy cycle 5 of MUL -> outputs at reset values next edge; no late valid_o.
